// File: rtl/snn_pkg.sv
// Shared types and defaults for the SNN spike I/O sequencer.
package snn_pkg;

    typedef enum logic [0:0] {
        SEQ_IDLE = 1'b0,
        SEQ_RUN  = 1'b1
    } seq_state_e;

    localparam int unsigned SNN_N_IN_DEF  = 8;
    localparam int unsigned SNN_N_OUT_DEF = 8;
    localparam int unsigned TIMER_W       = 16;

endpackage

// File: rtl/snn_frame_fifo.sv
// Synchronous frame FIFO; a push while full is accepted only if a pop frees a slot that cycle.
module snn_frame_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_drop
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [AW:0]      w_level;
    logic             w_full;
    logic             w_empty;
    logic             w_do_pop;
    logic             w_do_push;

    // Extra pointer MSB distinguishes full from empty.
    assign w_level   = r_wr_ptr - r_rd_ptr;
    assign w_full    = (w_level == (AW+1)'(DEPTH));
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_do_pop  = i_pop & ~w_empty;
    assign w_do_push = i_push & (~w_full | w_do_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

    assign o_data  = r_mem[r_rd_ptr[AW-1:0]];
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_level = w_level;
    assign o_drop  = i_push & ~w_do_push;

endmodule

// File: rtl/snn_spike_io_sequencer.sv
// Buffers pad-side spike frames and issues one per inference step to the SNN core,
// capturing its output and flagging dropped frames and step timeouts.
module snn_spike_io_sequencer
    import snn_pkg::*;
#(
    parameter int unsigned N_IN        = SNN_N_IN_DEF,
    parameter int unsigned N_OUT       = SNN_N_OUT_DEF,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          input_ready,
    input  logic [N_IN-1:0]               input_spikes,
    input  logic                          step_mode,
    input  logic                          step_req,
    input  logic                          clr_flags,
    input  logic [N_OUT-1:0]              snn_out_spikes,
    input  logic                          snn_out_valid,
    output logic                          snn_enable,
    output logic [N_IN-1:0]               snn_in_spikes,
    output logic [N_OUT-1:0]              out_spikes,
    output logic                          out_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic                          timeout,
    output logic                          busy
);

    seq_state_e           r_state, w_state_d;
    logic                 r_ready_q;
    logic                 r_push_q;
    logic [N_IN-1:0]      r_frame_q;
    logic [TIMER_W-1:0]   r_timer, w_timer_d;
    logic [N_IN-1:0]      r_in_spikes;
    logic [N_OUT-1:0]     r_out_spikes;
    logic                 r_out_valid;
    logic                 r_overflow;
    logic                 r_timeout;

    logic                 w_pop;
    logic                 w_capture;
    logic                 w_to_set;
    logic                 w_drop;
    logic                 w_full;
    logic                 w_empty;
    logic [N_IN-1:0]      w_head;

    snn_frame_fifo #(
        .WIDTH (N_IN),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (r_push_q),
        .i_data  (r_frame_q),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (fifo_level),
        .o_drop  (w_drop)
    );

    always_comb begin
        w_state_d = r_state;
        w_timer_d = r_timer;
        w_pop     = 1'b0;
        w_capture = 1'b0;
        w_to_set  = 1'b0;
        unique case (r_state)
            SEQ_IDLE: begin
                if (enable && !w_empty && (!step_mode || step_req)) begin
                    w_pop     = 1'b1;
                    w_timer_d = '0;
                    w_state_d = SEQ_RUN;
                end
            end
            SEQ_RUN: begin
                w_timer_d = r_timer + 1'b1;
                // Losing enable discards the step silently; a real result beats the timeout.
                if (!enable) begin
                    w_state_d = SEQ_IDLE;
                end else if (snn_out_valid) begin
                    w_capture = 1'b1;
                    w_state_d = SEQ_IDLE;
                end else if (r_timer == TIMER_W'(TIMEOUT_CYC - 1)) begin
                    w_to_set  = 1'b1;
                    w_state_d = SEQ_IDLE;
                end
            end
            default: w_state_d = SEQ_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= SEQ_IDLE;
            r_ready_q    <= 1'b0;
            r_push_q     <= 1'b0;
            r_frame_q    <= '0;
            r_timer      <= '0;
            r_in_spikes  <= '0;
            r_out_spikes <= '0;
            r_out_valid  <= 1'b0;
            r_overflow   <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_timer     <= w_timer_d;
            r_ready_q   <= input_ready;
            r_push_q    <= input_ready & ~r_ready_q;
            r_frame_q   <= input_spikes;
            r_out_valid <= w_capture;
            if (w_pop)     r_in_spikes  <= w_head;
            if (w_capture) r_out_spikes <= snn_out_spikes;
            r_overflow <= clr_flags ? 1'b0 : (r_overflow | w_drop);
            r_timeout  <= clr_flags ? 1'b0 : (r_timeout | w_to_set);
        end
    end

    assign snn_enable    = (r_state == SEQ_RUN);
    assign busy          = (r_state == SEQ_RUN);
    assign snn_in_spikes = r_in_spikes;
    assign out_spikes    = r_out_spikes;
    assign out_valid     = r_out_valid;
    assign overflow      = r_overflow;
    assign timeout       = r_timeout;

endmodule

// File: tb/tb_snn_spike_io_sequencer.sv
// Self-checking bench: directed vector table, hand-written corner sequences and a
// randomized run compared against a queue-based behavioural model.
module tb_snn_spike_io_sequencer;

    localparam int unsigned NI  = 8;
    localparam int unsigned NO  = 8;
    localparam int unsigned DEP = 4;
    localparam int unsigned TO  = 10;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic          input_ready = 1'b0;
    logic [NI-1:0] input_spikes = '0;
    logic          step_mode = 1'b0;
    logic          step_req = 1'b0;
    logic          clr_flags = 1'b0;
    logic [NO-1:0] snn_out_spikes = '0;
    logic          snn_out_valid = 1'b0;
    logic          snn_enable;
    logic [NI-1:0] snn_in_spikes;
    logic [NO-1:0] out_spikes;
    logic          out_valid;
    logic [2:0]    fifo_level;
    logic          overflow;
    logic          timeout;
    logic          busy;

    snn_spike_io_sequencer #(
        .N_IN        (NI),
        .N_OUT       (NO),
        .FIFO_DEPTH  (DEP),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .input_ready    (input_ready),
        .input_spikes   (input_spikes),
        .step_mode      (step_mode),
        .step_req       (step_req),
        .clr_flags      (clr_flags),
        .snn_out_spikes (snn_out_spikes),
        .snn_out_valid  (snn_out_valid),
        .snn_enable     (snn_enable),
        .snn_in_spikes  (snn_in_spikes),
        .out_spikes     (out_spikes),
        .out_valid      (out_valid),
        .fifo_level     (fifo_level),
        .overflow       (overflow),
        .timeout        (timeout),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Behavioural model: frames in a queue, a run flag and an elapsed-cycle count.
    bit         m_rdy_q, m_pend, m_run, m_outv, m_ov, m_to;
    logic [7:0] m_pdata, m_in, m_out;
    logic [7:0] m_q[$];
    int         m_elapsed;

    task automatic model_reset();
        m_rdy_q = 0; m_pend = 0; m_run = 0; m_outv = 0; m_ov = 0; m_to = 0;
        m_pdata = '0; m_in = '0; m_out = '0; m_elapsed = 0;
        m_q.delete();
    endtask

    task automatic model_step();
        bit pop, ovs, tos;
        pop = 0; ovs = 0; tos = 0;
        if (reset) begin
            model_reset();
            return;
        end
        pop = !m_run && enable && (m_q.size() != 0) && (!step_mode || step_req);
        m_outv = 0;
        if (m_run) begin
            if (!enable) m_run = 0;
            else if (snn_out_valid) begin
                m_out = snn_out_spikes; m_outv = 1; m_run = 0;
            end else if (m_elapsed == TO - 1) begin
                tos = 1; m_run = 0;
            end else m_elapsed++;
        end
        if (pop) begin
            m_in = m_q.pop_front(); m_run = 1; m_elapsed = 0;
        end
        if (m_pend) begin
            if (m_q.size() < DEP) m_q.push_back(m_pdata);
            else ovs = 1;
        end
        m_ov = clr_flags ? 0 : (m_ov | ovs);
        m_to = clr_flags ? 0 : (m_to | tos);
        m_pend  = input_ready && !m_rdy_q;
        m_pdata = input_spikes;
        m_rdy_q = input_ready;
    endtask

    function automatic logic [31:0] dut_vec();
        return {8'h0, snn_enable, busy, snn_in_spikes, out_spikes, out_valid, fifo_level,
                overflow, timeout};
    endfunction

    function automatic logic [31:0] model_vec();
        logic [2:0] lvl;
        lvl = 3'(m_q.size());
        return {8'h0, m_run, m_run, m_in, m_out, m_outv, lvl, m_ov, m_to};
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        chk("model", dut_vec(), model_vec());
    endtask

    task automatic push_frame(input logic [7:0] d);
        input_ready = 1'b1; input_spikes = d;
        cycle();
        input_ready = 1'b0;
        cycle();
    endtask

    task automatic wait_busy(input int max_cyc);
        for (int i = 0; i < max_cyc && !busy; i++) cycle();
        chk("wait_busy", {31'h0, busy}, 32'h1);
    endtask

    task automatic complete(input logic [7:0] v);
        snn_out_valid = 1'b1; snn_out_spikes = v;
        cycle();
        snn_out_valid = 1'b0;
    endtask

    typedef struct {
        logic       rdy;
        logic [7:0] spk;
        logic       vld;
        logic [7:0] ospk;
        logic       e_en;
        logic [7:0] e_in;
        logic [7:0] e_out;
        logic       e_ov;
        logic [2:0] e_lvl;
    } vec_t;

    vec_t tbl[8];
    int   run_len;

    initial begin
        tbl[0] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 3'd0};
        tbl[1] = '{1'b1, 8'hA5, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 3'd0};
        tbl[2] = '{1'b1, 8'hA5, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 3'd1};
        tbl[3] = '{1'b1, 8'hA5, 1'b0, 8'h00, 1'b1, 8'hA5, 8'h00, 1'b0, 3'd0};
        tbl[4] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'hA5, 8'h00, 1'b0, 3'd0};
        tbl[5] = '{1'b0, 8'h00, 1'b1, 8'h3C, 1'b0, 8'hA5, 8'h3C, 1'b1, 3'd0};
        tbl[6] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'hA5, 8'h3C, 1'b0, 3'd0};
        tbl[7] = '{1'b0, 8'h00, 1'b1, 8'hFF, 1'b0, 8'hA5, 8'h3C, 1'b0, 3'd0};

        model_reset();
        #1;
        chk("reset_outputs", dut_vec(), 32'h0);
        cycle();
        #2 reset = 1'b0;

        // 1: single frame through stream mode, 3-cycle issue latency
        enable = 1'b1;
        foreach (tbl[i]) begin
            input_ready = tbl[i].rdy; input_spikes = tbl[i].spk;
            snn_out_valid = tbl[i].vld; snn_out_spikes = tbl[i].ospk;
            cycle();
            chk($sformatf("vec%0d", i), {snn_enable, snn_in_spikes, out_spikes, out_valid,
                fifo_level}, {tbl[i].e_en, tbl[i].e_in, tbl[i].e_out, tbl[i].e_ov, tbl[i].e_lvl});
        end
        input_ready = 1'b0; snn_out_valid = 1'b0;

        // 2: overfill while disabled, then drain in order
        enable = 1'b0;
        for (int k = 1; k <= 5; k++) push_frame(8'(k));
        chk("t2_level", 32'(fifo_level), 32'd4);
        chk("t2_overflow", {31'h0, overflow}, 32'h1);
        enable = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            wait_busy(5);
            chk($sformatf("t2_order%0d", k), 32'(snn_in_spikes), 32'(k));
            complete(8'(8'h10 + k));
        end
        clr_flags = 1'b1; cycle(); clr_flags = 1'b0;
        chk("t2_clr", {31'h0, overflow}, 32'h0);

        // 3: single-step mode
        step_mode = 1'b1;
        push_frame(8'h11); push_frame(8'h22); cycle();
        chk("t3_hold", {busy, 3'b0, 1'b0, fifo_level}, {1'b0, 3'b0, 1'b0, 3'd2});
        step_req = 1'b1; cycle(); step_req = 1'b0;
        chk("t3_step1", {busy, snn_in_spikes, 5'b0, fifo_level}, {1'b1, 8'h11, 5'b0, 3'd1});
        complete(8'h5A);
        chk("t3_cap", {out_valid, out_spikes}, {1'b1, 8'h5A});
        cycle();
        chk("t3_no_auto", {busy, out_valid}, 2'b00);
        step_req = 1'b1; cycle(); step_req = 1'b0;
        chk("t3_step2", {busy, snn_in_spikes}, {1'b1, 8'h22});
        complete(8'h5B); cycle();
        step_req = 1'b1; cycle(); step_req = 1'b0;
        chk("t3_empty_req", {31'h0, busy}, 32'h0);
        push_frame(8'h33); cycle(); cycle();
        chk("t3_not_queued", {busy, fifo_level}, {1'b0, 3'd1});
        step_req = 1'b1; cycle(); step_req = 1'b0;
        chk("t3_step3", {busy, snn_in_spikes}, {1'b1, 8'h33});
        complete(8'h5C); cycle();
        step_mode = 1'b0;

        // 4: no valid from the core -> timeout after TO cycles of RUN
        push_frame(8'h77);
        wait_busy(5);
        run_len = 1;
        for (int i = 0; i < 50 && busy; i++) begin
            cycle();
            if (busy) run_len++;
        end
        chk("t4_run_len", 32'(run_len), 32'(TO));
        chk("t4_flag_hold", {timeout, out_valid, out_spikes}, {1'b1, 1'b0, 8'h5C});
        clr_flags = 1'b1; cycle(); clr_flags = 1'b0;
        chk("t4_clr", {31'h0, timeout}, 32'h0);

        // 5: push lands on a full FIFO in the same cycle as an issue
        enable = 1'b0;
        for (int k = 0; k < 4; k++) push_frame(8'(8'h41 + k));
        chk("t5_full", 32'(fifo_level), 32'd4);
        input_ready = 1'b1; input_spikes = 8'h99;
        cycle();
        enable = 1'b1;
        cycle();
        input_ready = 1'b0;
        chk("t5_push_pop", {busy, overflow, snn_in_spikes, 5'b0, fifo_level},
            {1'b1, 1'b0, 8'h41, 5'b0, 3'd4});

        // 6: drop enable mid-RUN, then async reset mid-RUN
        enable = 1'b0;
        cycle();
        chk("t6_abort", {snn_enable, out_valid, timeout, fifo_level}, {3'b000, 3'd4});
        enable = 1'b1;
        cycle();
        chk("t6_no_replay", {busy, snn_in_spikes}, {1'b1, 8'h42});
        #2 reset = 1'b1;
        #1;
        model_reset();
        chk("t6_async_reset", dut_vec(), 32'h0);
        cycle(); cycle();
        #2 reset = 1'b0;

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 2) == 0) input_ready = ~input_ready;
            input_spikes   = 8'($urandom);
            enable         = ($urandom_range(0, 19) != 0);
            if ($urandom_range(0, 99) == 0) step_mode = ~step_mode;
            step_req       = ($urandom_range(0, 3) == 0);
            clr_flags      = ($urandom_range(0, 15) == 0);
            snn_out_valid  = ($urandom_range(0, 5) == 0);
            snn_out_spikes = 8'($urandom);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
